// File: rtl/boot_mem.sv
// Boot RAM: a loader fills the image while the core is held in reset, then the core runs from it.
// Optional `BOOT_MEM_CHECKSUM_EN`: a trailing checksum byte must make the byte sum zero.
module boot_mem #(
    parameter int unsigned ADDR_W    = 12,
    parameter logic [15:0] LOAD_BASE = 16'h0200,
    parameter int unsigned LOAD_LEN  = 256
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [15:0] address,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    output logic [7:0]  rd_data,
    input  logic        load_valid,
    input  logic [7:0]  load_data,
    output logic        load_ready,
    output logic        proc_resetn,
    output logic        load_done,
    output logic        load_error
);

    localparam int unsigned MemDepth = 1 << ADDR_W;

    typedef enum logic [1:0] {StLoad, StRun, StError} state_e;

    state_e              state_q, state_d;
    logic [15:0]         count_q, count_d;
    logic [7:0]          mem [MemDepth];
    logic                accept;
    logic                load_we;
    logic                proc_we;
    logic                in_range;
    logic [ADDR_W-1:0]   load_idx;

    assign in_range   = 32'(address) < MemDepth;
    assign load_ready = (state_q == StLoad);
    assign accept     = load_valid && load_ready;
    assign load_idx   = ADDR_W'(LOAD_BASE + count_q);
    assign proc_we    = (state_q == StRun) && wr_en && in_range;

`ifdef BOOT_MEM_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;
    logic [7:0] sum_next;
    logic       cksum_byte;

    assign sum_next   = sum_q + load_data;
    assign cksum_byte = (count_q == 16'(LOAD_LEN));
    // The checksum byte only feeds the sum; it never lands in RAM.
    assign load_we    = accept && !cksum_byte;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        sum_d   = sum_q;
        unique case (state_q)
            StLoad: begin
                if (accept) begin
                    if (cksum_byte) begin
                        state_d = (sum_next == 8'h00) ? StRun : StError;
                    end else begin
                        count_d = count_q + 16'd1;
                        sum_d   = sum_next;
                    end
                end
            end
            StRun:   state_d = StRun;
            StError: state_d = StError;
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sum_q <= 8'h00;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign load_error = (state_q == StError);
`else
    logic last_byte;

    assign last_byte = (count_q == 16'(LOAD_LEN - 1));
    assign load_we   = accept;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        unique case (state_q)
            StLoad: begin
                if (accept) begin
                    count_d = count_q + 16'd1;
                    if (last_byte) begin
                        state_d = StRun;
                    end
                end
            end
            StRun:   state_d = StRun;
            StError: state_d = StError;
            default: state_d = StLoad;
        endcase
    end

    assign load_error = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StLoad;
            count_q <= 16'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // State is registered, so these rise on the edge that completes the load.
    assign proc_resetn = (state_q == StRun);
    assign load_done   = (state_q == StRun);

    // RAM is deliberately left out of reset so an aborted load keeps its partial image.
    always_ff @(posedge clk) begin
        if (load_we) begin
            mem[load_idx] <= load_data;
        end else if (proc_we) begin
            mem[address[ADDR_W-1:0]] <= wr_data;
        end
    end

    always_comb begin
        rd_data = 8'hEA;
        if (address == 16'hFFFC) begin
            rd_data = LOAD_BASE[7:0];
        end else if (address == 16'hFFFD) begin
            rd_data = LOAD_BASE[15:8];
        end else if (in_range) begin
            rd_data = mem[address[ADDR_W-1:0]];
        end
    end

endmodule

// File: tb/tb_boot_mem.sv
// Scoreboard bench for boot_mem with a 4-byte image; covers the checksum build when
// BOOT_MEM_CHECKSUM_EN is defined.
module tb_boot_mem;

    localparam int LEN = 4;
`ifdef BOOT_MEM_CHECKSUM_EN
    localparam int NB = LEN + 1;
`else
    localparam int NB = LEN;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic [15:0] address;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic [7:0]  rd_data;
    logic        load_valid;
    logic [7:0]  load_data;
    logic        load_ready;
    logic        proc_resetn;
    logic        load_done;
    logic        load_error;

    logic [7:0]  model [4096];
    logic [7:0]  exp_q [$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;

    boot_mem #(
        .ADDR_W    (12),
        .LOAD_BASE (16'h0200),
        .LOAD_LEN  (LEN)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .address     (address),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_data     (rd_data),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .proc_resetn (proc_resetn),
        .load_done   (load_done),
        .load_error  (load_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_rd(input logic [15:0] a);
        if (a == 16'hFFFC) return 8'h00;
        if (a == 16'hFFFD) return 8'h02;
        if (a < 16'h1000) return model[int'(a)];
        return 8'hEA;
    endfunction

    task automatic rd_chk(input string tag, input logic [15:0] a);
        address = a;
        exp_q.push_back(exp_rd(a));
        #1;
        check(tag, rd_data, exp_q.pop_front());
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn     = 1'b0;
        load_valid = 1'b0;
        wr_en      = 1'b0;
        #1;
        check("rst_prst", proc_resetn, 1'b0);
        check("rst_done", load_done, 1'b0);
        check("rst_err", load_error, 1'b0);
        check("rst_rdy", load_ready, 1'b1);
        @(negedge clk);
        resetn = 1'b1;
        cyc    = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int g = 0; g < gap; g++) begin
            load_valid = 1'b0;
            @(negedge clk);
            cyc++;
        end
        load_valid = 1'b1;
        load_data  = b;
        @(negedge clk);
        cyc++;
        load_valid = 1'b0;
    endtask

    // Sends n program bytes of img (MSB first); a full load also checks release timing.
    task automatic load_img(input logic [31:0] img, input int gap, input int n, input bit bad_ck);
        logic [7:0] b;
        logic [7:0] sum;
        sum = 8'h00;
        for (int i = 0; i < n; i++) begin
            b = img[31-8*i -: 8];
            send_byte(b, gap);
            model[16'h200 + i] = b;
            sum = sum + b;
            check($sformatf("prst_b%0d", i), proc_resetn, (NB == LEN) && (i == LEN - 1));
        end
        if (n == LEN) begin
`ifdef BOOT_MEM_CHECKSUM_EN
            b = 8'h00 - sum + {7'd0, bad_ck};
            send_byte(b, gap);
`endif
            check("rel_cyc", cyc, NB * (gap + 1));
            check("rel_rdy", load_ready, 1'b0);
            if (bad_ck) begin
                check("err_flag", load_error, 1'b1);
                check("err_prst", proc_resetn, 1'b0);
                check("err_done", load_done, 1'b0);
            end else begin
                check("run_prst", proc_resetn, 1'b1);
                check("run_done", load_done, 1'b1);
                check("run_err", load_error, 1'b0);
            end
        end
    endtask

    initial begin
        resetn     = 1'b0;
        address    = 16'h0000;
        wr_en      = 1'b0;
        wr_data    = 8'h00;
        load_valid = 1'b0;
        load_data  = 8'h00;

        // Back-to-back load
        do_reset();
        load_img(32'hEA4C0002, 0, LEN, 1'b0);
        rd_chk("rd_200", 16'h0200);
        rd_chk("rd_201", 16'h0201);
        rd_chk("rd_202", 16'h0202);
        rd_chk("rd_203", 16'h0203);
        rd_chk("rd_fffc", 16'hFFFC);
        rd_chk("rd_fffd", 16'hFFFD);
        rd_chk("rd_9000", 16'h9000);

        // RUN-state processor writes
        address = 16'h0010; wr_data = 8'h5A; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        model[16'h10] = 8'h5A;
        rd_chk("wr_0010", 16'h0010);

        // Write colliding with a read shows old data this cycle
        address = 16'h0010; wr_data = 8'hA5; wr_en = 1'b1;
        exp_q.push_back(exp_rd(16'h0010));
        #1;
        check("wr_old", rd_data, exp_q.pop_front());
        @(negedge clk);
        wr_en = 1'b0;
        model[16'h10] = 8'hA5;
        rd_chk("wr_new", 16'h0010);

        address = 16'h8000; wr_data = 8'h33; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        rd_chk("wr_8000", 16'h8000);

        // Toggled valid, with a processor write attempted throughout the load
        do_reset();
        address = 16'h0010; wr_data = 8'h77; wr_en = 1'b1;
        load_img(32'hEA4C0002, 1, LEN, 1'b0);
        wr_en = 1'b0;
        rd_chk("ld_wr_0010", 16'h0010);
        rd_chk("tg_200", 16'h0200);
        rd_chk("tg_203", 16'h0203);

        // Abort mid-load, then full reload
        do_reset();
        load_img(32'hAABB0000, 0, 2, 1'b0);
        do_reset();
        load_img(32'h11223344, 0, LEN, 1'b0);
        rd_chk("rl_200", 16'h0200);
        rd_chk("rl_201", 16'h0201);
        rd_chk("rl_202", 16'h0202);
        rd_chk("rl_203", 16'h0203);

`ifdef BOOT_MEM_CHECKSUM_EN
        do_reset();
        load_img(32'h01020304, 0, LEN, 1'b1);
        repeat (3) @(negedge clk);
        check("err_hold", load_error, 1'b1);
        check("err_hold_prst", proc_resetn, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
